line_mem_ctrl: RTL and testbench

LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 12 +
 rtl/mem_ctrl_defines.sv | 6 +
 rtl/line_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_line_mem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Constants and FSM state encoding shared by the line memory controller.
package mem_ctrl_pkg;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LAST,
    ST_RESP
  } state_e;
endpackage

// File: rtl/mem_ctrl_defines.sv
// Shared address and cache-line width macros for the memory controller slice.
`ifndef MEM_CTRL_DEFINES_SV
`define MEM_CTRL_DEFINES_SV
`define ADDR_WIDTH 32
`define DATA_WIDTH_CACHE 128
`endif

// File: rtl/line_mem_ctrl.sv
// Splits one cache-line read or write into four 32-bit SRAM beats, with
// WAIT_CYCLES idle cycles after every beat, and reports completion with rvalid_o.
`ifndef ADDR_WIDTH
`include "mem_ctrl_defines.sv"
`endif

module line_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [`ADDR_WIDTH-1:0]       addr_i,
  input  logic [`DATA_WIDTH_CACHE-1:0] wdata_i,
  input  logic                         we_i,
  input  logic                         cs_i,
  output logic [`DATA_WIDTH_CACHE-1:0] rdata_o,
  output logic                         rvalid_o,
  output logic [`ADDR_WIDTH-3:0]       sram_addr_o,
  output logic [WORD_W-1:0]            sram_wdata_o,
  output logic                         sram_en_o,
  output logic                         sram_we_o,
  input  logic [WORD_W-1:0]            sram_rdata_i
);
  localparam int         LINE_W = `DATA_WIDTH_CACHE;
  localparam int         TAG_W  = `ADDR_WIDTH - 4;
  localparam logic [3:0] WAIT_W = 4'(WAIT_CYCLES);
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_e            state, state_n;
  logic [TAG_W-1:0]  line_addr;
  logic [LINE_W-1:0] line_wdata, rd_buf, line_next;
  logic              is_write, rd_pending;
  logic [1:0]        beat, rd_idx;
  logic [3:0]        phase;
  logic              beat_done;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr_i[3:0];
  assign beat_done        = (phase == WAIT_W);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  // A beat strobes on phase 0; phases 1..WAIT_W are the idle gap after it.
  always_comb begin
    state_n   = state;
    sram_en_o = 1'b0;
    rvalid_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_i) state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        sram_en_o = (phase == 4'd0);
        if (beat_done && beat == LAST_BEAT) state_n = is_write ? ST_RESP : ST_LAST;
      end
      ST_LAST: begin
        state_n = ST_RESP;
      end
      ST_RESP: begin
        rvalid_o = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign sram_we_o    = sram_en_o & is_write;
  assign sram_addr_o  = sram_en_o ? {line_addr, beat} : '0;
  assign sram_wdata_o = sram_en_o ? line_wdata[beat*WORD_W +: WORD_W] : '0;

  // The last read word may still be in flight during LAST, so merge it here.
  always_comb begin
    line_next = rd_buf;
    if (rd_pending) line_next[rd_idx*WORD_W +: WORD_W] = sram_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_addr  <= '0;
      line_wdata <= '0;
      is_write   <= 1'b0;
      beat       <= 2'd0;
      phase      <= 4'd0;
      rd_pending <= 1'b0;
      rd_idx     <= 2'd0;
      rd_buf     <= '0;
      rdata_o    <= '0;
    end else begin
      rd_pending <= sram_en_o & ~is_write;
      rd_idx     <= beat;
      if (rd_pending) rd_buf[rd_idx*WORD_W +: WORD_W] <= sram_rdata_i;
      case (state)
        ST_IDLE: begin
          if (cs_i) begin
            line_addr  <= addr_i[`ADDR_WIDTH-1:4];
            line_wdata <= wdata_i;
            is_write   <= we_i;
            beat       <= 2'd0;
            phase      <= 4'd0;
          end
        end
        ST_ACCESS: begin
          if (beat_done) begin
            phase <= 4'd0;
            if (beat != LAST_BEAT) beat <= beat + 2'd1;
          end else begin
            phase <= phase + 4'd1;
          end
        end
        ST_LAST: rdata_o <= line_next;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: two instances (WAIT_CYCLES 0 and 3), each with its own
// SRAM model, checked every cycle against a timeline model plus literal expectations.
module tb_line_mem_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic         we;
  logic         cs     [2];
  logic [127:0] rdata  [2];
  logic         rv     [2];
  logic [29:0]  s_addr [2];
  logic [31:0]  s_wd   [2];
  logic [31:0]  s_rd   [2];
  logic         s_en   [2];
  logic         s_we   [2];

  logic [31:0]  mem     [2][256];
  logic [31:0]  mem_exp [2][256];
  bit           busy    [2];
  int           m_t     [2];
  logic [27:0]  m_addr  [2];
  logic [127:0] m_wdata [2];
  bit           m_we    [2];
  logic [127:0] rd_exp  [2];
  int           strobe_cnt [2];
  logic [29:0]  strobe_q0 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata), .we_i(we), .cs_i(cs[0]),
    .rdata_o(rdata[0]), .rvalid_o(rv[0]), .sram_addr_o(s_addr[0]), .sram_wdata_o(s_wd[0]),
    .sram_en_o(s_en[0]), .sram_we_o(s_we[0]), .sram_rdata_i(s_rd[0])
  );

  line_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata), .we_i(we), .cs_i(cs[1]),
    .rdata_o(rdata[1]), .rvalid_o(rv[1]), .sram_addr_o(s_addr[1]), .sram_wdata_o(s_wd[1]),
    .sram_en_o(s_en[1]), .sram_we_o(s_we[1]), .sram_rdata_i(s_rd[1])
  );

  function automatic logic [31:0] preload(input int i);
    if (i >= 16 && i < 20) return 32'h11 * 32'(i - 15);
    return 32'hA500_0000 + 32'(i);
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM: writes commit on the strobe edge, read data appears the cycle after.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (s_en[g]) begin
        if (s_we[g]) mem[g][s_addr[g][7:0]] <= s_wd[g];
        else         s_rd[g] <= mem[g][s_addr[g][7:0]];
      end
    end
  end

  // Timeline model: after acceptance, beat k strobes at cycle 1+k*(1+W); completion
  // follows at 4*(1+W)+1 (write) or +2 (read).
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int per;
      int lat;
      int k;
      bit exp_en;
      bit exp_rv;
      logic [29:0] exp_addr;
      per = (g == 0) ? 1 : 4;
      lat = m_we[g] ? 4 * per + 1 : 4 * per + 2;
      if (!rst_n) begin
        busy[g]   = 1'b0;
        m_t[g]    = 0;
        rd_exp[g] = '0;
      end
      exp_en   = busy[g] && m_t[g] >= 1 && m_t[g] <= 4 * per && ((m_t[g] - 1) % per == 0);
      k        = (m_t[g] >= 1) ? (m_t[g] - 1) / per : 0;
      exp_addr = {m_addr[g], 2'(k)};
      exp_rv   = busy[g] && (m_t[g] == lat);
      if (exp_rv && !m_we[g])
        for (int j = 0; j < 4; j++) rd_exp[g][32*j +: 32] = mem_exp[g][{m_addr[g][5:0], 2'(j)}];

      check_output($sformatf("u%0d_en", g), 128'(s_en[g]), 128'(exp_en));
      check_output($sformatf("u%0d_we", g), 128'(s_we[g]), 128'(exp_en && m_we[g]));
      check_output($sformatf("u%0d_rvalid", g), 128'(rv[g]), 128'(exp_rv));
      check_output($sformatf("u%0d_rdata", g), rdata[g], rd_exp[g]);
      if (exp_en) check_output($sformatf("u%0d_addr", g), 128'(s_addr[g]), 128'(exp_addr));
      if (exp_en && m_we[g]) begin
        check_output($sformatf("u%0d_wdata", g), 128'(s_wd[g]), 128'(m_wdata[g][32*k +: 32]));
        mem_exp[g][exp_addr[7:0]] = m_wdata[g][32*k +: 32];
      end
      if (!rst_n) begin
        check_output($sformatf("u%0d_rst_addr", g), 128'(s_addr[g]), '0);
        check_output($sformatf("u%0d_rst_wdata", g), 128'(s_wd[g]), '0);
      end

      if (s_en[g]) begin
        strobe_cnt[g]++;
        if (g == 0) strobe_q0.push_back(s_addr[0]);
      end

      if (busy[g]) begin
        if (m_t[g] == lat) busy[g] = 1'b0;
        else               m_t[g]++;
      end else if (rst_n && cs[g]) begin
        busy[g]    = 1'b1;
        m_t[g]     = 1;
        m_addr[g]  = addr[31:4];
        m_wdata[g] = wdata;
        m_we[g]    = we;
      end
    end
  end

  // Issues one request and returns the cycle count from acceptance to rvalid_o.
  task automatic apply_stimulus(input int g, input logic [31:0] a, input logic [127:0] d,
                                input logic w, input bit keep_cs, input bit drop,
                                output int cycles);
    @(posedge clk); #1;
    addr  = a;
    wdata = d;
    we    = w;
    cs[g] = 1'b1;
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      if (rv[g]) break;
      @(posedge clk); #1;
      cycles++;
      if (drop && cycles == 1) begin
        cs[g] = 1'b0;
        addr  = 32'hFFFF_FFF0;
        wdata = '1;
        we    = ~w;
      end
    end
    if (cycles >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL u%0d_timeout: got no rvalid_o within 40 cycles, expected one", g);
    end
    if (!keep_cs) cs[g] = 1'b0;
  endtask

  initial begin
    int lat;
    int c0;
    rst_n = 1'b0;
    cs[0] = 1'b0;
    cs[1] = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) begin
        mem[g][i]     <= preload(i);
        mem_exp[g][i]  = preload(i);
      end
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_rdata", rdata[0], '0);
    check_output("reset_rvalid", 128'(rv[0]), '0);
    check_output("reset_en", 128'(s_en[1]), '0);
    rst_n = 1'b1;

    apply_stimulus(0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, lat);
    check_output("rd_latency_w0", 128'(lat), 128'd6);
    check_output("rd_data_w0", rdata[0], 128'h00000044_00000033_00000022_00000011);

    c0 = strobe_q0.size();
    apply_stimulus(0, 32'h0000_0080, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 1'b1, 1'b0, 1'b0, lat);
    check_output("wr_latency_w0", 128'(lat), 128'd5);
    check_output("wr_rdata_hold", rdata[0], 128'h00000044_00000033_00000022_00000011);
    check_output("wr_strobes", 128'(strobe_q0.size() - c0), 128'd4);
    check_output("wr_first_addr", 128'(strobe_q0[c0]), 128'h20);
    check_output("wr_last_addr", 128'(strobe_q0[c0+3]), 128'h23);

    apply_stimulus(0, 32'h0000_0080, '0, 1'b0, 1'b0, 1'b0, lat);
    check_output("wr_readback", rdata[0], 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA);

    apply_stimulus(1, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, lat);
    check_output("rd_latency_w3", 128'(lat), 128'd18);
    check_output("rd_data_w3", rdata[1], 128'h00000044_00000033_00000022_00000011);
    apply_stimulus(1, 32'h0000_0080, 128'h1, 1'b1, 1'b0, 1'b0, lat);
    check_output("wr_latency_w3", 128'(lat), 128'd17);

    apply_stimulus(0, 32'h0000_0080, '0, 1'b0, 1'b1, 1'b0, lat);
    addr = 32'h0000_0100;
    c0 = strobe_q0.size();
    apply_stimulus(0, 32'h0000_0100, '0, 1'b0, 1'b0, 1'b0, lat);
    check_output("b2b_latency", 128'(lat), 128'd6);
    check_output("b2b_first_addr", 128'(strobe_q0[c0]), 128'h40);
    check_output("b2b_last_addr", 128'(strobe_q0[c0+3]), 128'h43);
    check_output("b2b_data", rdata[0], 128'hA5000043_A5000042_A5000041_A5000040);

    apply_stimulus(0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b1, lat);
    check_output("drop_latency", 128'(lat), 128'd6);
    check_output("drop_data", rdata[0], 128'h00000044_00000033_00000022_00000011);

    c0 = strobe_cnt[0];
    @(posedge clk); #1;
    addr  = 32'h0000_00C0;
    wdata = 128'h00004444_00003333_00002222_00001111;
    we    = 1'b1;
    cs[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    cs[0] = 1'b0;
    @(negedge clk);
    check_output("midrst_rdata", rdata[0], '0);
    check_output("midrst_en", 128'(s_en[0]), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_output("midrst_strobes", 128'(strobe_cnt[0] - c0), 128'd2);
    apply_stimulus(0, 32'h0000_00C0, '0, 1'b0, 1'b0, 1'b0, lat);
    check_output("midrst_rd_latency", 128'(lat), 128'd6);
    check_output("midrst_partial", rdata[0], 128'hA5000033_A5000032_00002222_00001111);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
